// File: rtl/exec_control_alu.sv
// exec_control_alu: registered decode-and-execute stage.
//   Decodes main control from the opcode and ALU control from ALUOp/funct7/funct3,
//   selects operand B (imm or rs2_data), runs a 64-bit ALU with signed divide and
//   registers every output for a one-cycle latency.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   instruction       - fetched instruction (opcode, funct3, funct7 used)
//   rs1_data          - ALU operand A
//   rs2_data, imm     - operand B candidates
//   branch .. alu_op  - registered main control
//   alu_ctrl          - registered ALU operation code
//   result, remainder - registered ALU outputs (remainder is 0 except for DIV)
//   zero              - registered (result == 0) flag
module exec_control_alu #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            branch,
  output logic            mem_read,
  output logic            mem_reg,
  output logic            mem_write,
  output logic            alu_src,
  output logic            reg_write,
  output logic [1:0]      alu_op,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] remainder,
  output logic            zero
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSra  = 4'b1000;
  localparam logic [3:0] AluMul  = 4'b1001;
  localparam logic [3:0] AluDiv  = 4'b1010;
  localparam logic [3:0] AluSltu = 4'b1011;

  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = '1;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic            w_unused_bits;
  logic            w_branch, w_mem_read, w_mem_reg, w_mem_write, w_alu_src, w_reg_write;
  logic [1:0]      w_alu_op;
  logic [3:0]      w_alu_ctrl;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_rem;

  assign w_opcode      = instruction[6:0];
  assign w_funct3      = instruction[14:12];
  assign w_funct7      = instruction[31:25];
  assign w_unused_bits = ^{instruction[24:15], instruction[11:7]};

  // Shared funct3 map for the funct7=0000000 R-type group and I-type ALU ops.
  function automatic logic [3:0] funct3_map(input logic [2:0] f3);
    case (f3)
      3'b000:  funct3_map = AluAdd;
      3'b001:  funct3_map = AluSll;
      3'b010:  funct3_map = AluSlt;
      3'b011:  funct3_map = AluSltu;
      3'b100:  funct3_map = AluXor;
      3'b101:  funct3_map = AluSrl;
      3'b110:  funct3_map = AluOr;
      default: funct3_map = AluAnd;
    endcase
  endfunction

  always_comb begin
    {w_branch, w_mem_read, w_mem_reg, w_mem_write, w_alu_src, w_reg_write} = 6'b000000;
    w_alu_op = 2'b00;
    case (w_opcode)
      OpRType:  begin w_reg_write = 1'b1; w_alu_op = 2'b10; end
      OpIAlu:   begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = 2'b11; end
      OpLoad:   begin
        w_mem_read  = 1'b1;
        w_mem_reg   = 1'b1;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OpStore:  begin w_mem_write = 1'b1; w_alu_src = 1'b1; end
      OpBranch: begin w_branch = 1'b1; w_alu_op = 2'b01; end
      default:  ;
    endcase
  end

  always_comb begin
    w_alu_ctrl = AluAdd;
    case (w_alu_op)
      2'b01: w_alu_ctrl = AluSub;
      2'b10: begin
        case (w_funct7)
          7'b0000000: w_alu_ctrl = funct3_map(w_funct3);
          7'b0100000: begin
            if (w_funct3 == 3'b000)      w_alu_ctrl = AluSub;
            else if (w_funct3 == 3'b101) w_alu_ctrl = AluSra;
          end
          7'b0000001: begin
            if (w_funct3 == 3'b000)      w_alu_ctrl = AluMul;
            else if (w_funct3 == 3'b100) w_alu_ctrl = AluDiv;
          end
          default: ;
        endcase
      end
      2'b11: begin
        // I-type: funct7 only distinguishes SRAI from SRLI.
        w_alu_ctrl = funct3_map(w_funct3);
        if (w_funct3 == 3'b101 && w_funct7 == 7'b0100000) w_alu_ctrl = AluSra;
      end
      default: ;
    endcase
  end

  assign w_b = w_alu_src ? imm : rs2_data;

  always_comb begin
    w_result = '0;
    w_rem    = '0;
    case (w_alu_ctrl)
      AluAnd:  w_result = rs1_data & w_b;
      AluOr:   w_result = rs1_data | w_b;
      AluXor:  w_result = rs1_data ^ w_b;
      AluAdd:  w_result = rs1_data + w_b;
      AluSub:  w_result = rs1_data - w_b;
      AluSll:  w_result = rs1_data << w_b[5:0];
      AluSrl:  w_result = rs1_data >> w_b[5:0];
      AluSra:  w_result = $signed(rs1_data) >>> w_b[5:0];
      AluSlt:  w_result = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(w_b)};
      AluSltu: w_result = {{(XLEN-1){1'b0}}, rs1_data < w_b};
      AluMul:  w_result = rs1_data * w_b;
      AluDiv: begin
        // Boundary cases are explicit; the native operators leave them undefined.
        if (w_b == '0) begin
          w_result = AllOnes;
          w_rem    = rs1_data;
        end else if (rs1_data == MinNeg && w_b == AllOnes) begin
          w_result = rs1_data;
        end else begin
          w_result = $signed(rs1_data) / $signed(w_b);
          w_rem    = $signed(rs1_data) % $signed(w_b);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch    <= 1'b0;
      mem_read  <= 1'b0;
      mem_reg   <= 1'b0;
      mem_write <= 1'b0;
      alu_src   <= 1'b0;
      reg_write <= 1'b0;
      alu_op    <= 2'b00;
      alu_ctrl  <= 4'b0000;
      result    <= '0;
      remainder <= '0;
      zero      <= 1'b0;
    end else begin
      branch    <= w_branch;
      mem_read  <= w_mem_read;
      mem_reg   <= w_mem_reg;
      mem_write <= w_mem_write;
      alu_src   <= w_alu_src;
      reg_write <= w_reg_write;
      alu_op    <= w_alu_op;
      alu_ctrl  <= w_alu_ctrl;
      result    <= w_result;
      remainder <= w_rem;
      zero      <= (w_result == '0);
    end
  end

endmodule

// File: tb/tb_exec_control_alu.sv
module tb_exec_control_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = '0;
  logic [63:0] rs1_data = '0, rs2_data = '0, imm = '0;
  logic        branch, mem_read, mem_reg, mem_write, alu_src, reg_write, zero;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [63:0] result, remainder;

  typedef struct packed {
    logic [5:0]  ctl;  // {branch, mem_read, mem_reg, mem_write, alu_src, reg_write}
    logic [1:0]  op;
    logic [3:0]  ac;
    logic [63:0] res;
    logic [63:0] rem;
    logic        z;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  exec_control_alu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .branch(branch), .mem_read(mem_read), .mem_reg(mem_reg), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op), .alu_ctrl(alu_ctrl),
    .result(result), .remainder(remainder), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] op);
    mk = {f7, 10'b0, f3, 5'b0, op};
  endfunction

  function automatic exp_t ex(input logic [5:0] ctl, input logic [1:0] op,
                              input logic [3:0] ac, input logic [63:0] res,
                              input logic [63:0] rem);
    ex.ctl = ctl; ex.op = op; ex.ac = ac; ex.res = res; ex.rem = rem; ex.z = (res == 64'd0);
  endfunction

  task automatic compare_out(input string name);
    exp_t e;
    if (q.size() == 0) begin
      check({name, ".queue"}, 64'd0, 64'd1);
    end else begin
      e = q.pop_front();
      check({name, ".ctl"}, {58'd0, branch, mem_read, mem_reg, mem_write, alu_src, reg_write},
            {58'd0, e.ctl});
      check({name, ".alu_op"}, {62'd0, alu_op}, {62'd0, e.op});
      check({name, ".alu_ctrl"}, {60'd0, alu_ctrl}, {60'd0, e.ac});
      check({name, ".result"}, result, e.res);
      check({name, ".remainder"}, remainder, e.rem);
      check({name, ".zero"}, {63'd0, zero}, {63'd0, e.z});
    end
  endtask

  task automatic send(input string name, input logic [31:0] ins, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] im, input exp_t e);
    @(negedge clk);
    instruction = ins; rs1_data = a; rs2_data = b; imm = im;
    q.push_back(e);
    @(posedge clk);
    #1;
    compare_out(name);
  endtask

  task automatic check_reset(input string name);
    check({name, ".ctl"}, {52'd0, branch, mem_read, mem_reg, mem_write, alu_src, reg_write,
          alu_op, alu_ctrl}, 64'd0);
    check({name, ".result"}, result, 64'd0);
    check({name, ".remainder"}, remainder, 64'd0);
    check({name, ".zero"}, {63'd0, zero}, 64'd0);
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, UNK = 7'b1111111;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    // Reset held across a clock edge with live ADD inputs: outputs stay 0.
    instruction = mk(7'b0000000, 3'b000, R); rs1_data = 64'd5; rs2_data = 64'd7;
    @(posedge clk); #1;
    check_reset("rst_hold");
    @(negedge clk); rst = 1'b0;

    send("add", mk(7'b0000000, 3'b000, R), 64'd5, 64'd7, 64'd99,
         ex(6'b000001, 2'b10, 4'b0010, 64'd12, 64'd0));
    send("load", mk(7'b0000000, 3'b011, LD), 64'h1000, 64'hFFFF, 64'h10,
         ex(6'b011011, 2'b00, 4'b0010, 64'h1010, 64'd0));

    // Asynchronous reset mid-operation, away from any edge.
    #2 rst = 1'b1;
    #1 check_reset("rst_async");
    @(negedge clk); rst = 1'b0;

    send("add2", mk(7'b0000000, 3'b000, R), 64'd5, 64'd7, 64'd0,
         ex(6'b000001, 2'b10, 4'b0010, 64'd12, 64'd0));
    send("store", mk(7'b0000000, 3'b011, ST), 64'h1000, 64'hFFFF, 64'h10,
         ex(6'b000110, 2'b00, 4'b0010, 64'h1010, 64'd0));
    send("beq", mk(7'b0000000, 3'b000, BR), 64'd42, 64'd42, 64'd8,
         ex(6'b100000, 2'b01, 4'b0110, 64'd0, 64'd0));
    send("bne", mk(7'b0000000, 3'b000, BR), 64'd42, 64'd41, 64'd8,
         ex(6'b100000, 2'b01, 4'b0110, 64'd1, 64'd0));
    send("sub", mk(7'b0100000, 3'b000, R), 64'd3, 64'd5, 64'd0,
         ex(6'b000001, 2'b10, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0));
    send("sra", mk(7'b0100000, 3'b101, R), MIN, 64'd4, 64'd0,
         ex(6'b000001, 2'b10, 4'b1000, 64'hF800_0000_0000_0000, 64'd0));
    send("srl", mk(7'b0000000, 3'b101, R), MIN, 64'd4, 64'd0,
         ex(6'b000001, 2'b10, 4'b0101, 64'h0800_0000_0000_0000, 64'd0));
    send("sll", mk(7'b0000000, 3'b001, R), 64'd1, 64'd63, 64'd0,
         ex(6'b000001, 2'b10, 4'b0100, MIN, 64'd0));
    send("slt", mk(7'b0000000, 3'b010, R), NEG1, 64'd1, 64'd0,
         ex(6'b000001, 2'b10, 4'b0111, 64'd1, 64'd0));
    send("sltu", mk(7'b0000000, 3'b011, R), NEG1, 64'd1, 64'd0,
         ex(6'b000001, 2'b10, 4'b1011, 64'd0, 64'd0));
    send("xor", mk(7'b0000000, 3'b100, R), 64'hF0, 64'hFF, 64'd0,
         ex(6'b000001, 2'b10, 4'b0011, 64'h0F, 64'd0));
    send("or", mk(7'b0000000, 3'b110, R), 64'hF0, 64'h0F, 64'd0,
         ex(6'b000001, 2'b10, 4'b0001, 64'hFF, 64'd0));
    send("and", mk(7'b0000000, 3'b111, R), 64'hF0, 64'h3C, 64'd0,
         ex(6'b000001, 2'b10, 4'b0000, 64'h30, 64'd0));
    send("div", mk(7'b0000001, 3'b100, R), -64'sd7, 64'd2, 64'd0,
         ex(6'b000001, 2'b10, 4'b1010, -64'sd3, NEG1));
    send("div0", mk(7'b0000001, 3'b100, R), 64'd7, 64'd0, 64'd0,
         ex(6'b000001, 2'b10, 4'b1010, NEG1, 64'd7));
    send("divovf", mk(7'b0000001, 3'b100, R), MIN, NEG1, 64'd0,
         ex(6'b000001, 2'b10, 4'b1010, MIN, 64'd0));
    send("mul", mk(7'b0000001, 3'b000, R), 64'd3, -64'sd4, 64'd0,
         ex(6'b000001, 2'b10, 4'b1001, -64'sd12, 64'd0));
    send("r_undef", mk(7'b0000001, 3'b001, R), 64'd10, 64'd6, 64'd0,
         ex(6'b000001, 2'b10, 4'b0010, 64'd16, 64'd0));
    send("unknown", mk(7'b0000000, 3'b000, UNK), 64'd10, 64'd20, 64'd100,
         ex(6'b000000, 2'b00, 4'b0010, 64'd30, 64'd0));
    send("addi", mk(7'b0000000, 3'b000, I), 64'd5, 64'd999, NEG1,
         ex(6'b000011, 2'b11, 4'b0010, 64'd4, 64'd0));
    send("addi_f7", mk(7'b0100000, 3'b000, I), 64'd10, 64'd999, 64'd3,
         ex(6'b000011, 2'b11, 4'b0010, 64'd13, 64'd0));
    send("srai", mk(7'b0100000, 3'b101, I), -64'sd16, 64'd999, 64'h402,
         ex(6'b000011, 2'b11, 4'b1000, -64'sd4, 64'd0));
    send("srli", mk(7'b0000000, 3'b101, I), -64'sd16, 64'd999, 64'd2,
         ex(6'b000011, 2'b11, 4'b0101, 64'h3FFF_FFFF_FFFF_FFFC, 64'd0));
    send("sltiu", mk(7'b0000000, 3'b011, I), 64'd1, 64'd0, NEG1,
         ex(6'b000011, 2'b11, 4'b1011, 64'd1, 64'd0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
